// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module   : rf_wb_arbiter_if
// Purpose  : Bundles the writeback request handshake and the register-file
//            write port of rf_wb_arbiter.
//            - slave  : the arbiter side (consumes requests, drives the RF port)
//            - master : the requester / environment side
// Signals  : hold_i       grant blocker
//            req_valid_i  per-requester request
//            req_ready_o  per-requester accept (combinational)
//            req_adr_i    packed destination addresses, NB_REGS bits each
//            req_data_i   packed write data, XLEN bits each
//            write_*_o    register file write port
//            busy_o       one-hot of the register held in the output stage
//            grant_id_o   requester that produced the output-stage entry
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
    parameter int NB_REQ  = 3,
    parameter int XLEN    = 32,
    parameter int NB_REGS = 5
);
    localparam int c_ID_W = $clog2(NB_REQ);
    localparam int c_NREG = 2 ** NB_REGS;

    logic                        hold_i;
    logic [NB_REQ-1:0]           req_valid_i;
    logic [NB_REQ-1:0]           req_ready_o;
    logic [NB_REQ*NB_REGS-1:0]   req_adr_i;
    logic [NB_REQ*XLEN-1:0]      req_data_i;
    logic                        write_valid_o;
    logic [NB_REGS-1:0]          write_adr_o;
    logic [XLEN-1:0]             write_data_o;
    logic [c_NREG-1:0]           busy_o;
    logic [c_ID_W-1:0]           grant_id_o;

    modport slave (
        input  hold_i,
        input  req_valid_i,
        output req_ready_o,
        input  req_adr_i,
        input  req_data_i,
        output write_valid_o,
        output write_adr_o,
        output write_data_o,
        output busy_o,
        output grant_id_o
    );

    modport master (
        output hold_i,
        output req_valid_i,
        input  req_ready_o,
        output req_adr_i,
        output req_data_i,
        input  write_valid_o,
        input  write_adr_o,
        input  write_data_o,
        input  busy_o,
        input  grant_id_o
    );

endinterface : rf_wb_arbiter_if

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the single register-file write port between NB_REQ
//            writeback requesters. Round-robin arbitration picks one request
//            per cycle; the winner is registered in a one-entry output stage
//            that drives the RF write port one cycle after acceptance and
//            exports a one-hot busy map of the in-flight destination.
// Ports    : clk    rising-edge clock
//            reset  asynchronous active-high reset
//            bus    rf_wb_arbiter_if.slave (requests in, RF write port out)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
    parameter int NB_REQ  = 3,
    parameter int XLEN    = 32,
    parameter int NB_REGS = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rf_wb_arbiter_if.slave     bus
);

    localparam int                  c_ID_W       = $clog2(NB_REQ);
    localparam int                  c_NREG       = 2 ** NB_REGS;
    // Pointer arithmetic is done one bit wider so ptr + offset never overflows
    // before the explicit wrap (needed when NB_REQ is not a power of two).
    localparam logic [c_ID_W:0]     c_NB_REQ_EXT = (c_ID_W + 1)'(NB_REQ);
    localparam logic [c_ID_W-1:0]   c_LAST_ID    = c_ID_W'(NB_REQ - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [NB_REGS-1:0]  out_adr_q,   out_adr_d;
    logic [XLEN-1:0]     out_data_q,  out_data_d;
    logic [c_ID_W-1:0]   out_id_q,    out_id_d;

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic [c_ID_W:0]     w_idx;
    logic                w_found;
    logic [c_ID_W-1:0]   w_gnt_id;
    logic                w_grant_ok;
    logic [NB_REQ-1:0]   w_ready;
    logic [NB_REGS-1:0]  w_gnt_adr;
    logic [XLEN-1:0]     w_gnt_data;
    logic [c_NREG-1:0]   w_busy;

    // Scan from rr_ptr_q upwards with wrap; the first valid index wins.
    always_comb begin : p_arbitrate
        w_idx    = '0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            w_idx = {1'b0, rr_ptr_q} + (c_ID_W + 1)'(i);
            if (w_idx >= c_NB_REQ_EXT) begin
                w_idx = w_idx - c_NB_REQ_EXT;
            end
            if (!w_found && bus.req_valid_i[w_idx[c_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[c_ID_W-1:0];
            end
        end
    end

    // Reset is folded in combinationally so no request is acknowledged while
    // the block is held in reset.
    assign w_grant_ok = w_found & ~bus.hold_i & ~reset;

    always_comb begin : p_ready
        w_ready = '0;
        if (w_grant_ok) begin
            w_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_gnt_adr  = bus.req_adr_i [w_gnt_id * NB_REGS +: NB_REGS];
    assign w_gnt_data = bus.req_data_i[w_gnt_id * XLEN    +: XLEN];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin : p_next
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = 1'b0;         // the RF always drains the stage
        out_adr_d   = out_adr_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (w_grant_ok) begin
            rr_ptr_d    = (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + 1'b1;
            out_adr_d   = w_gnt_adr;
            out_data_d  = w_gnt_data;
            out_id_d    = w_gnt_id;
            // x0 is hard-wired zero: accept the request but never write it.
            out_valid_d = |w_gnt_adr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_adr_q   <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_adr_q   <= out_adr_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    // ------------------------------------------------------------------------
    // Busy map: one-hot of the destination currently in the output stage.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_NREG; i++) begin : g_busy
            assign w_busy[i] = out_valid_q & (out_adr_q == NB_REGS'(i));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready_o   = w_ready;
    assign bus.write_valid_o = out_valid_q;
    assign bus.write_adr_o   = out_adr_q;
    assign bus.write_data_o  = out_data_q;
    assign bus.grant_id_o    = out_id_q;
    assign bus.busy_o        = w_busy;

endmodule : rf_wb_arbiter

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Self-checking bench for rf_wb_arbiter. A reference round-robin
//            model predicts ready bits each cycle; accepted non-x0 writes are
//            queued and compared against the RF write port one cycle later.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

    localparam int NB_REQ  = 3;
    localparam int XLEN    = 32;
    localparam int NB_REGS = 5;
    localparam int ID_W    = $clog2(NB_REQ);
    localparam int NREG    = 2 ** NB_REGS;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NB_REQ(NB_REQ), .XLEN(XLEN), .NB_REGS(NB_REGS)) bus ();

    rf_wb_arbiter #(
        .NB_REQ  (NB_REQ),
        .XLEN    (XLEN),
        .NB_REGS (NB_REGS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file image built from the write port.
    logic [XLEN-1:0] rf [NREG];
    always @(posedge clk) begin
        if (bus.write_valid_o) rf[bus.write_adr_o] <= bus.write_data_o;
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [NB_REGS-1:0] adr;
        logic [XLEN-1:0]    data;
        logic [ID_W-1:0]    id;
    } wr_t;

    wr_t                exp_q[$];
    int                 m_ptr;
    logic [NB_REGS-1:0] m_adr;
    logic [XLEN-1:0]    m_data;
    logic [ID_W-1:0]    m_id;

    task automatic model_reset();
        m_ptr  = 0;
        m_adr  = '0;
        m_data = '0;
        m_id   = '0;
        exp_q.delete();
    endtask

    task automatic set_req(input int k, input logic [NB_REGS-1:0] adr, input logic [XLEN-1:0] data);
        bus.req_valid_i[k]                     = 1'b1;
        bus.req_adr_i[k*NB_REGS +: NB_REGS]    = adr;
        bus.req_data_i[k*XLEN +: XLEN]         = data;
    endtask

    task automatic clr_req(input int k);
        bus.req_valid_i[k] = 1'b0;
    endtask

    // Called just after a rising edge with inputs already driven. Checks the
    // ready bits mid-cycle, then the write port after the next rising edge.
    task automatic cycle(input string tag, output int gnt);
        int                g;
        bit                acc;
        logic [NB_REQ-1:0] erdy;
        logic [NREG-1:0]   ebusy;
        wr_t               w;
        g = -1;
        for (int i = 0; i < NB_REQ; i++) begin
            int k;
            k = (m_ptr + i) % NB_REQ;
            if (g < 0 && bus.req_valid_i[k]) g = k;
        end
        acc  = (g >= 0) && !bus.hold_i;
        erdy = '0;
        if (acc) erdy[g] = 1'b1;
        @(negedge clk);
        check({tag, ":ready"}, 64'(bus.req_ready_o), 64'(erdy));
        if (acc) begin
            w.adr  = bus.req_adr_i[g*NB_REGS +: NB_REGS];
            w.data = bus.req_data_i[g*XLEN +: XLEN];
            w.id   = g[ID_W-1:0];
            m_adr  = w.adr;
            m_data = w.data;
            m_id   = w.id;
            if (w.adr != '0) exp_q.push_back(w);
            m_ptr = (g + 1) % NB_REQ;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w     = exp_q.pop_front();
            ebusy = '0;
            ebusy[w.adr] = 1'b1;
            check({tag, ":wvalid"}, 64'(bus.write_valid_o), 64'(1'b1));
            check({tag, ":wadr"},   64'(bus.write_adr_o),   64'(w.adr));
            check({tag, ":wdata"},  64'(bus.write_data_o),  64'(w.data));
            check({tag, ":gid"},    64'(bus.grant_id_o),    64'(w.id));
            check({tag, ":busy"},   64'(bus.busy_o),        64'(ebusy));
        end else begin
            check({tag, ":wvalid"}, 64'(bus.write_valid_o), 64'(1'b0));
            check({tag, ":busy"},   64'(bus.busy_o),        64'(0));
            check({tag, ":wadr_hold"},  64'(bus.write_adr_o),  64'(m_adr));
            check({tag, ":wdata_hold"}, 64'(bus.write_data_o), 64'(m_data));
            check({tag, ":gid_hold"},   64'(bus.grant_id_o),   64'(m_id));
        end
        gnt = acc ? g : -1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int g;
        reset           = 1'b1;
        bus.hold_i      = 1'b0;
        bus.req_valid_i = '0;
        bus.req_adr_i   = '0;
        bus.req_data_i  = '0;
        model_reset();

        // Reset with every requester asking: nothing may be acknowledged.
        set_req(0, 5'd1, 32'hA);
        set_req(1, 5'd2, 32'hB);
        set_req(2, 5'd3, 32'hC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:ready",  64'(bus.req_ready_o),   64'(0));
        check("rst:wvalid", 64'(bus.write_valid_o), 64'(0));
        check("rst:wadr",   64'(bus.write_adr_o),   64'(0));
        check("rst:wdata",  64'(bus.write_data_o),  64'(0));
        check("rst:busy",   64'(bus.busy_o),        64'(0));
        check("rst:gid",    64'(bus.grant_id_o),    64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin over three always-valid requesters.
        for (int i = 0; i < 6; i++) begin
            cycle("rr", g);
            check("rr:gnt", 64'(g), 64'(i % NB_REQ));
        end
        clr_req(0); clr_req(1); clr_req(2);
        cycle("idle0", g);
        check("idle0:gnt", 64'(g), 64'(-1));

        // Single requester 1.
        set_req(1, 5'd5, 32'hDEADBEEF);
        cycle("r1", g);
        check("r1:gnt", 64'(g), 64'(1));
        check("r1:busy_abs", 64'(bus.busy_o), 64'(32'h0000_0020));
        clr_req(1);
        cycle("r1_after", g);

        // Write to x0: accepted, never written. Pointer goes 2 -> 0 -> 1.
        set_req(0, 5'd0, 32'h1234);
        cycle("x0", g);
        check("x0:gnt", 64'(g), 64'(0));
        clr_req(0);
        // Pointer at 1: req1 must beat req0.
        set_req(0, 5'd10, 32'h55);
        set_req(1, 5'd11, 32'h66);
        cycle("ptr1a", g);
        check("ptr1a:gnt", 64'(g), 64'(1));
        clr_req(1);
        cycle("ptr1b", g);
        check("ptr1b:gnt", 64'(g), 64'(0));
        clr_req(0);
        set_req(1, 5'd12, 32'h99);
        cycle("to_ptr2", g);
        clr_req(1);

        // Same destination from req0 and req2 with pointer at 2.
        set_req(0, 5'd7, 32'h11);
        set_req(2, 5'd7, 32'h22);
        cycle("x7a", g);
        check("x7a:gnt", 64'(g), 64'(2));
        clr_req(2);
        cycle("x7b", g);
        check("x7b:gnt", 64'(g), 64'(0));
        clr_req(0);
        cycle("x7_idle", g);
        check("x7:rf", 64'(rf[7]), 64'(32'h11));

        // Hold: the output stage drains, no grants, pointer frozen.
        set_req(1, 5'd9, 32'h9999);
        cycle("pre_hold", g);
        clr_req(1);
        set_req(0, 5'd4, 32'h44);
        bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("hold", g);
            check("hold:gnt", 64'(g), 64'(-1));
        end
        bus.hold_i = 1'b0;
        cycle("unhold", g);
        check("unhold:gnt", 64'(g), 64'(0));
        clr_req(0);

        // Reset in the middle of a write: the in-flight entry is dropped.
        set_req(2, 5'd13, 32'h77);
        cycle("pre_rst", g);
        check("pre_rst:gnt", 64'(g), 64'(2));
        clr_req(2);
        set_req(0, 5'd3, 32'h33);
        reset = 1'b1;
        #1;
        check("midrst:wvalid", 64'(bus.write_valid_o), 64'(0));
        check("midrst:busy",   64'(bus.busy_o),        64'(0));
        check("midrst:ready",  64'(bus.req_ready_o),   64'(0));
        check("midrst:wadr",   64'(bus.write_adr_o),   64'(0));
        @(posedge clk);
        #1;
        check("midrst2:wvalid", 64'(bus.write_valid_o), 64'(0));
        reset = 1'b0;
        model_reset();
        cycle("post_rst", g);
        check("post_rst:gnt", 64'(g), 64'(0));
        clr_req(0);
        cycle("final_idle", g);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_rf_wb_arbiter

`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between NB_REQ writeback requesters (ALU, LSU, MUL/CSR).
- Arbitrates round-robin and registers the winning write in a one-entry output stage.
- Drives the register file write port (write_valid/write_adr/write_data) one cycle after acceptance.
- Exports a busy bitmap of the in-flight write so the issue stage can stall or bypass.

Parameters:
- NB_REQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- NB_REGS, 5, register address width; register count is 2**NB_REGS.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- hold_i  input  1  blocks all new grants this cycle; the output stage still drains.
- req_valid_i  input  NB_REQ  per-requester write request.
- req_ready_o  output  NB_REQ  per-requester grant/accept, combinational.
- req_adr_i  input  NB_REQ*NB_REGS  packed destination addresses; requester k occupies slice [k*NB_REGS +: NB_REGS].
- req_data_i  input  NB_REQ*XLEN  packed write data; requester k occupies slice [k*XLEN +: XLEN].
- write_valid_o  output  1  register file write enable.
- write_adr_o  output  NB_REGS  register file write address.
- write_data_o  output  XLEN  register file write data.
- busy_o  output  2**NB_REGS  one-hot of the register in the output stage; all zero when the stage is empty.
- grant_id_o  output  $clog2(NB_REQ)  index of the requester that produced the current output-stage entry (debug/trace).

Behaviour:
- State:
  - rr_ptr_q, $clog2(NB_REQ) bits.
  - Output stage: out_valid_q, out_adr_q, out_data_q, out_id_q.
- Reset (asynchronous assert, clocked release):
  - rr_ptr_q = 0; out_valid_q = 0; out_adr_q = 0; out_data_q = 0; out_id_q = 0.
  - Therefore write_valid_o = 0, write_adr_o = 0, write_data_o = 0, busy_o = 0, grant_id_o = 0.
  - req_ready_o = 0 while reset is high.
- Arbitration (combinational):
  - Search req_valid_i starting at index rr_ptr_q, ascending, wrapping from NB_REQ-1 to 0.
  - The first valid index g wins. req_ready_o[g] = 1; every other ready bit is 0.
  - At most one ready bit is ever high.
  - If hold_i = 1 or no request is valid, all ready bits are 0.
- Accept: valid & ready on requester g at a rising edge. Then:
  - rr_ptr_q <= (g == NB_REQ-1) ? 0 : g+1.
  - out_id_q <= g.
  - out_adr_q and out_data_q <= requester g's slices.
  - out_valid_q <= 1, except when the address is 0.
- No accept: out_valid_q <= 0 and rr_ptr_q holds. The register file always accepts, so the output stage is always drained after one cycle.
- Writes to x0: accepted normally (ready asserted, pointer advances) but never produce write_valid_o, and bit 0 of busy_o never sets.
- Latency: accept in cycle N -> write_valid_o high in cycle N+1 only. Throughput is one write per cycle.
- Output mapping:
  - write_valid_o = out_valid_q; write_adr_o = out_adr_q; write_data_o = out_data_q; grant_id_o = out_id_q.
  - Outputs hold their last value when out_valid_q = 0, except write_valid_o.
- busy_o[i] = out_valid_q & (out_adr_q == i).
- Same destination from two requesters in one cycle: only the granted one is accepted. The other stays pending and is written in a later cycle (last write wins in the register file).
- Requester protocol: once req_valid_i[k] is high, it and its adr/data stay stable until accepted. Violation is a checker error, not handled in RTL.
- hold_i:
  - Lowers all ready bits and freezes rr_ptr_q.
  - A write already in the output stage still retires the next cycle.
- Reset asserted mid-operation: an in-flight output-stage write is dropped (write_valid_o falls immediately); pending requests are not accepted.
- NB_REQ not a power of two: the pointer wraps explicitly at NB_REQ-1 and never takes values >= NB_REQ.

Test Plan:
- Reset with all req_valid_i = 1 -> req_ready_o = 000 during reset; after release, ready = 001 (ptr 0); next cycle write_valid_o = 1 with req0's adr/data.
- All three requesters held valid (adr 1/2/3, data 0xA/0xB/0xC) for 6 cycles -> grants 0,1,2,0,1,2; write_adr_o sequence 1,2,3,1,2,3 each one cycle after acceptance; ptr wraps 2 -> 0.
- Only req1 valid, adr 5, data 0xDEADBEEF -> ready = 010 that cycle; next cycle write_valid_o = 1, write_adr_o = 5, write_data_o = 0xDEADBEEF, busy_o = 0x00000020, grant_id_o = 1; the following cycle write_valid_o = 0, busy_o = 0.
- req0 writes adr 0 with data 0x1234 -> ready[0] = 1, next cycle write_valid_o = 0 and busy_o = 0; ptr advances to 1.
- req0 and req2 both valid to adr 7 (data 0x11, 0x22) with ptr = 2 -> req2 written first (0x22), then req0 (0x11); final RF content for x7 = 0x11.
- hold_i = 1 for 3 cycles with req0 valid, output stage full from prior cycle -> pending write retires next cycle, ready stays 000 and ptr unchanged during hold; req0 accepted the first cycle hold_i = 0.
